// File: rtl/updown_counter_if.sv
// Control and status bundle for updown_counter.
// The master side drives the controls and reads the count, snapshot and event pulses.
interface updown_counter_if #(
  parameter int WIDTH = 32
);
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             dir;
  logic [WIDTH-1:0] cmp_val;
  logic             snap;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] snap_val;
  logic             at_max;
  logic             at_zero;
  logic             ovf;
  logic             unf;
  logic             cmp_hit;

  modport master (
    output clear, load, load_val, en, dir, cmp_val, snap,
    input  count, snap_val, at_max, at_zero, ovf, unf, cmp_hit
  );

  modport slave (
    input  clear, load, load_val, en, dir, cmp_val, snap,
    output count, snap_val, at_max, at_zero, ovf, unf, cmp_hit
  );
endinterface

// File: rtl/updown_counter.sv
// Parametrised up/down counter with wrap/saturate limits, load/clear, compare match,
// overflow/underflow pulses and a snapshot register for coherent software reads.
module updown_counter #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter bit               SAT_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  updown_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             hit_q, hit_d;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] c);
    if (c == MAX_VAL) return SAT_MODE ? MAX_VAL : ZERO;
    return c + ONE;
  endfunction

  function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] c);
    if (c == ZERO) return SAT_MODE ? ZERO : MAX_VAL;
    return c - ONE;
  endfunction

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    snap_d  = bus.snap ? count_q : snap_q;
    if (bus.clear) begin
      count_d = ZERO;
    end else if (bus.load) begin
      count_d = clamp_load(bus.load_val);
    end else if (bus.en) begin
      if (bus.dir) begin
        ovf_d   = (count_q == MAX_VAL);
        count_d = step_up(count_q);
      end else begin
        unf_d   = (count_q == ZERO);
        count_d = step_down(count_q);
      end
    end
    // An unchanged count (hold, saturation, reload of same value) never re-fires the match.
    hit_d = (count_d == bus.cmp_val) && (count_d != count_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= ZERO;
      snap_q  <= ZERO;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      snap_q  <= snap_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      hit_q   <= hit_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.snap_val = snap_q;
  assign bus.at_max   = (count_q == MAX_VAL);
  assign bus.at_zero  = (count_q == ZERO);
  assign bus.ovf      = ovf_q;
  assign bus.unf      = unf_q;
  assign bus.cmp_hit  = hit_q;

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench: a wrapping and a saturating counter (WIDTH=4, MAX_VAL=9) share one stimulus;
// expectations are queued as each step is driven and checked after the following edge.
module tb_updown_counter;

  logic       clk;
  logic       rst;
  logic       clear, load, en, dir, snap;
  logic [3:0] load_val, cmp_val;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    int         which;
    logic [3:0] cnt;
    logic [3:0] snp;
    logic [4:0] flg;  // {ovf, unf, cmp_hit, at_max, at_zero}
  } exp_t;

  exp_t sb[$];

  updown_counter_if #(.WIDTH(4)) bus0 ();
  updown_counter_if #(.WIDTH(4)) bus1 ();

  assign bus0.clear = clear;  assign bus1.clear = clear;
  assign bus0.load = load;    assign bus1.load = load;
  assign bus0.load_val = load_val; assign bus1.load_val = load_val;
  assign bus0.en = en;        assign bus1.en = en;
  assign bus0.dir = dir;      assign bus1.dir = dir;
  assign bus0.cmp_val = cmp_val; assign bus1.cmp_val = cmp_val;
  assign bus0.snap = snap;    assign bus1.snap = snap;

  updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SAT_MODE(1'b0)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SAT_MODE(1'b1)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic c, input logic l, input logic [3:0] lv,
                       input logic e, input logic d, input logic s);
    rst = r; clear = c; load = l; load_val = lv; en = e; dir = d; snap = s;
  endtask

  task automatic push_exp(input int which, input string tag, input logic [3:0] cnt,
                          input logic [3:0] snp, input logic [4:0] flg);
    exp_t e;
    e.tag = tag; e.cnt = cnt; e.snp = snp; e.flg = flg;
    if (which == 2) begin
      e.which = 0; sb.push_back(e);
      e.which = 1; sb.push_back(e);
    end else begin
      e.which = which; sb.push_back(e);
    end
  endtask

  task automatic tick();
    exp_t       e;
    logic [3:0] oc, os;
    logic [4:0] of;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.which == 0) begin
        oc = bus0.count; os = bus0.snap_val;
        of = {bus0.ovf, bus0.unf, bus0.cmp_hit, bus0.at_max, bus0.at_zero};
      end else begin
        oc = bus1.count; os = bus1.snap_val;
        of = {bus1.ovf, bus1.unf, bus1.cmp_hit, bus1.at_max, bus1.at_zero};
      end
      n_assert++;
      assert (oc === e.cnt) else begin
        n_fail++;
        $error("FAIL %s[dut%0d] count: observed %0d expected %0d", e.tag, e.which, oc, e.cnt);
      end
      n_assert++;
      assert (os === e.snp) else begin
        n_fail++;
        $error("FAIL %s[dut%0d] snap_val: observed %0d expected %0d", e.tag, e.which, os, e.snp);
      end
      n_assert++;
      assert (of === e.flg) else begin
        n_fail++;
        $error("FAIL %s[dut%0d] {ovf,unf,hit,max,zero}: observed %b expected %b",
               e.tag, e.which, of, e.flg);
      end
    end
  endtask

  initial begin
    cmp_val = 4'd15;
    drive(0, 0, 0, 4'd0, 0, 0, 0);
    push_exp(2, "reset", 4'd0, 4'd0, 5'b00001); tick();

    // Count up through the top of range on both variants.
    for (int i = 1; i <= 10; i++) begin
      drive(1, 0, 0, 4'd0, 1, 1, 0);
      if (i < 10) begin
        push_exp(2, "up", 4'(i), 4'd0, (i == 9) ? 5'b00010 : 5'b00000);
      end else begin
        push_exp(0, "wrap_ovf", 4'd0, 4'd0, 5'b10001);
        push_exp(1, "sat_ovf", 4'd9, 4'd0, 5'b10010);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 4'd0, 1, 1, 0);
      push_exp(1, "sat_hold", 4'd9, 4'd0, 5'b10010); tick();
    end

    // Decrement from zero.
    drive(0, 0, 0, 4'd0, 1, 1, 0);
    push_exp(2, "reset2", 4'd0, 4'd0, 5'b00001); tick();
    drive(1, 0, 0, 4'd0, 1, 0, 0);
    push_exp(0, "dn_wrap", 4'd9, 4'd0, 5'b01010);
    push_exp(1, "dn_sat", 4'd0, 4'd0, 5'b01001); tick();
    drive(1, 0, 0, 4'd0, 0, 0, 0);
    push_exp(0, "dn_idle", 4'd9, 4'd0, 5'b00010);
    push_exp(1, "dn_idle", 4'd0, 4'd0, 5'b00001); tick();

    // Priority and load clamping.
    drive(0, 0, 0, 4'd0, 0, 0, 0);
    push_exp(2, "reset3", 4'd0, 4'd0, 5'b00001); tick();
    drive(1, 0, 1, 4'd12, 1, 1, 0);
    push_exp(2, "clamp", 4'd9, 4'd0, 5'b00010); tick();
    drive(1, 1, 1, 4'd5, 1, 1, 0);
    push_exp(2, "clr_wins", 4'd0, 4'd0, 5'b00001); tick();
    drive(1, 0, 1, 4'd12, 1, 1, 0);
    push_exp(2, "clamp2", 4'd9, 4'd0, 5'b00010); tick();
    drive(1, 1, 0, 4'd0, 0, 0, 0);
    push_exp(2, "clear", 4'd0, 4'd0, 5'b00001); tick();
    drive(1, 0, 1, 4'd2, 1, 0, 0);
    push_exp(2, "load_no_unf", 4'd2, 4'd0, 5'b00000); tick();

    // Compare match.
    cmp_val = 4'd3;
    drive(0, 0, 0, 4'd0, 0, 0, 0);
    push_exp(2, "reset4", 4'd0, 4'd0, 5'b00001); tick();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 0, 4'd0, 1, 1, 0);
      push_exp(2, "cmp_up", 4'(i), 4'd0, (i == 3) ? 5'b00100 : 5'b00000); tick();
    end
    drive(1, 0, 1, 4'd7, 0, 0, 0);
    push_exp(2, "load7", 4'd7, 4'd0, 5'b00000); tick();
    drive(1, 0, 1, 4'd3, 0, 0, 0);
    push_exp(2, "load3_hit", 4'd3, 4'd0, 5'b00100); tick();
    drive(1, 0, 1, 4'd3, 0, 0, 0);
    push_exp(2, "reload3", 4'd3, 4'd0, 5'b00000); tick();
    cmp_val = 4'd4;
    drive(1, 0, 0, 4'd0, 0, 0, 0);
    push_exp(2, "cmp_chg", 4'd3, 4'd0, 5'b00000); tick();
    drive(1, 0, 0, 4'd0, 1, 1, 0);
    push_exp(2, "cmp4_hit", 4'd4, 4'd0, 5'b00100); tick();
    cmp_val = 4'd9;
    drive(1, 0, 1, 4'd8, 0, 0, 0);
    push_exp(2, "load8", 4'd8, 4'd0, 5'b00000); tick();
    drive(1, 0, 0, 4'd0, 1, 1, 0);
    push_exp(2, "cmp9_hit", 4'd9, 4'd0, 5'b00110); tick();
    drive(1, 0, 0, 4'd0, 1, 1, 0);
    push_exp(0, "cmp9_wrap", 4'd0, 4'd0, 5'b10001);
    push_exp(1, "cmp9_sat", 4'd9, 4'd0, 5'b10010); tick();

    // Snapshot and mid-operation reset.
    cmp_val = 4'd15;
    drive(0, 0, 0, 4'd0, 0, 0, 0);
    push_exp(2, "reset5", 4'd0, 4'd0, 5'b00001); tick();
    drive(1, 0, 1, 4'd6, 0, 0, 0);
    push_exp(2, "load6", 4'd6, 4'd0, 5'b00000); tick();
    drive(1, 0, 0, 4'd0, 1, 1, 1);
    push_exp(2, "snap6", 4'd7, 4'd6, 5'b00000); tick();
    drive(1, 0, 0, 4'd0, 1, 1, 0);
    push_exp(2, "snap_hold", 4'd8, 4'd6, 5'b00000); tick();
    drive(1, 1, 0, 4'd0, 1, 1, 1);
    push_exp(2, "snap_clr", 4'd0, 4'd8, 5'b00001); tick();
    drive(1, 0, 0, 4'd0, 1, 1, 0);
    push_exp(2, "run", 4'd1, 4'd8, 5'b00000); tick();
    drive(0, 0, 1, 4'd5, 1, 1, 1);
    push_exp(2, "rst_mid", 4'd0, 4'd0, 5'b00001); tick();

    drive(1, 0, 0, 4'd0, 0, 0, 0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_counter.md
Name: updown_counter

Overview:
- Parametrised up/down counter for position and odometry accumulation. Successor to the fixed 32-bit up-only counter.
- Adds the following over its predecessor:
  - configurable width and modulus
  - direction control
  - wrap or saturate mode
  - parallel load and synchronous clear
  - compare match
  - overflow/underflow event pulses
  - a snapshot register, so software reads a coherent value while the counter keeps running
- Sits between the encoder/step-pulse conditioning logic and the position register file.

Parameters:
- WIDTH, 32, counter width in bits (2..64).
- MAX_VAL, 2^WIDTH-1, terminal count; the counter range is 0..MAX_VAL inclusive.
- SAT_MODE, 0, 0 = wrap at the range limits, 1 = saturate (hold) at the range limits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- clear  in  1  synchronous clear of count to 0.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  value to load; values above MAX_VAL are clamped to MAX_VAL.
- en  in  1  count enable; one step per cycle while high.
- dir  in  1  1 = increment, 0 = decrement.
- cmp_val  in  WIDTH  compare value.
- snap  in  1  capture request.
- count  out  WIDTH  current count, registered.
- snap_val  out  WIDTH  last captured count, registered.
- at_max  out  1  combinational: count == MAX_VAL.
- at_zero  out  1  combinational: count == 0.
- ovf  out  1  registered 1-cycle pulse: increment attempted at MAX_VAL.
- unf  out  1  registered 1-cycle pulse: decrement attempted at 0.
- cmp_hit  out  1  registered 1-cycle pulse: count newly became equal to cmp_val.

Behaviour:
- Reset (rst low at an edge): count=0, snap_val=0, ovf=unf=cmp_hit=0. Reset has priority over every other input, including mid-count and mid-load.
- Update priority per edge: rst > clear > load > en.
  - clear: count<=0.
  - load: count<=min(load_val, MAX_VAL).
  - en only: step per dir.
- Step, increment:
  - count<MAX_VAL: count+1.
  - count==MAX_VAL: next = 0 (SAT_MODE=0) or MAX_VAL (SAT_MODE=1); ovf=1 for the next cycle in both modes.
- Step, decrement:
  - count>0: count-1.
  - count==0: next = MAX_VAL (SAT_MODE=0) or 0 (SAT_MODE=1); unf=1 for the next cycle in both modes.
- ovf/unf are only produced by an en step. They are never produced by load or clear, or when en is overridden by clear/load in the same cycle.
- All arithmetic is WIDTH bits. The MAX_VAL comparison is exact equality; there is no intermediate wider overflow.
- Latency: the count change is visible one cycle after the sampling edge. ovf/unf/cmp_hit are aligned with that new count value.
- cmp_hit=1 in the cycle after an edge where all of the following hold:
  - next_count == cmp_val
  - next_count != count
  - the update came from clear, load or an en step
- Saturation holding at cmp_val does not repeat cmp_hit. A change of cmp_val alone does not fire cmp_hit.
- snap: snap_val <= count, the pre-update value present at that edge. This is independent of clear/load/en in the same cycle. snap_val holds otherwise.
- at_max/at_zero are decoded from the registered count; they are glitch-free relative to clk.
- When en=0 and there is no clear/load, count holds and all pulses deassert.
- MAX_VAL=2^WIDTH-1 with SAT_MODE=0 reproduces natural binary wrap.

Test Plan:
- Wrap, WIDTH=4, MAX_VAL=9: reset, en=1, dir=1 for 10 cycles.
  - count 1..9 then 0.
  - ovf high only in the cycle count reads 0.
  - at_max high while count=9.
- Saturate, MAX_VAL=9, SAT_MODE=1: hold at count=9 with en=1, dir=1 for 3 cycles.
  - count stays 9.
  - ovf pulses each attempt.
- Down from 0, SAT_MODE=0, MAX_VAL=9: count goes 0->9 with unf=1 for one cycle.
  - With SAT_MODE=1: count stays 0 and unf pulses.
- Priority, single edge: clear=1, load=1 (load_val=5), en=1.
  - count=0; no ovf/unf.
  - Next edge, load=1, en=1, load_val=12 (MAX_VAL=9): count=9 (clamped).
- Compare, cmp_val=3, counting up from 0:
  - cmp_hit is a single pulse when count becomes 3.
  - load_val=3 from count=7: cmp_hit pulses.
  - Reloading 3 while count=3: no pulse.
- Snapshot and reset: snap at count=6 with en=1 -> snap_val=6, count=7.
  - Then rst=0 for one edge mid-count -> count=0, snap_val=0, all pulses 0.
